instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetches 16-bit instructions from instruction memory and feeds the processor core ("top").
//  Holds each instruction stable until the core accepts it, then advances the PC by +1 or to a branch target.
//  Stops fetching on the end-of-file word 16'h0000.
//  Sits directly upstream of top: its instruction output drives top.instruction.
// PARAMETERS
//  ADDR_WIDTH  10      instruction-memory word-address width; PC width
//  INSTR_WIDTH 16      instruction word width
//  RESET_PC    0       PC value loaded on reset
// PORTS
//  clk            in   1            system clock; one clock, all state on its rising edge
//  rst            in   1            reset; asynchronous, active-low (0 = reset)
//  imem_req       out  1            one-cycle read strobe to instruction memory
//  imem_addr      out  ADDR_WIDTH   word address; valid while imem_req=1
//  imem_rdata     in   INSTR_WIDTH  read data; sampled only when imem_rvalid=1
//  imem_rvalid    in   1            read-data strobe; >=1 cycle after imem_req
//  instruction    out  INSTR_WIDTH  instruction to core; stable while instr_valid=1
//  instr_valid    out  1            instruction holds a fetched word
//  core_ready     in   1            core accepts instruction this cycle (ignored unless instr_valid=1)
//  branch_en      in   1            take branch_target as next PC; sampled only at acceptance
//  branch_target  in   ADDR_WIDTH   next PC when branch_en=1 at acceptance
//  pc             out  ADDR_WIDTH   address of the instruction held or being fetched
//  halted         out  1            EOF word accepted; fetch stopped
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0, halted=0.
//  FSM states: IDLE, REQ, WAIT, HOLD, HALT.
//   IDLE: first clock edge after rst deasserts -> REQ.
//   REQ: imem_req=1, imem_addr=pc for exactly one cycle -> WAIT.
//   WAIT: imem_req=0. On imem_rvalid: instruction<=imem_rdata, instr_valid<=1 -> HOLD.
//   HOLD: instruction and pc held. Acceptance = instr_valid & core_ready:
//     - instruction==16'h0000: instr_valid<=0, halted<=1 -> HALT.
//     - else: instr_valid<=0; pc<=branch_en ? branch_target : pc+1 -> REQ.
//   HALT: all outputs frozen, halted=1. Exit only via reset.
//  Single outstanding request. imem_rvalid outside WAIT is ignored with no state change.
//  Latency: memory latency L cycles -> instr_valid rises L+1 edges after REQ entry.
//   Minimum period per instruction = L+2 cycles plus core hold time.
//  pc+1 wraps modulo 2^ADDR_WIDTH: max address -> 0, no flag.
//  branch_en/branch_target are don't-care outside acceptance. If branch_en coincides with EOF acceptance, HALT wins.
//  core_ready held high continuously: one acceptance per fetched word, never a double advance.
//  rst asserted mid-WAIT/HOLD: immediate return to reset values. The pending memory read is dropped.
//  instruction keeps its last value when instr_valid=0. Consumers qualify it with instr_valid.
// STRUCTURE
//  Shared package fetch_pkg: state enum (IDLE/REQ/WAIT/HOLD/HALT), EOF_INSTR = 16'h0000,
//   default widths shared with top and the register file.
//  Natural sub-module: pc_counter (load / increment-with-wrap / hold, async active-low reset).
//  Everything else is a single FSM plus the instruction register.
// TESTING
//  1 Reset release, mem L=1, mem[0]=16'h4142 -> imem_req at addr 0 one cycle; instr_valid=1, instruction=16'h4142 two edges later.
//  2 Program {0:5306, 1:9205, 2:0000}, core_ready pulsed 6 cycles after each valid -> pc sequence 0,1,2;
//    5306 and 9205 presented in order; halted=1 after 0000 accepted; no further imem_req.
//  3 At pc=1 accept with branch_en=1, branch_target=8 -> next imem_addr=8; pc+1 rule resumes at 9.
//  4 ADDR_WIDTH=4, start pc=15, accept -> next imem_addr=0, no halt.
//  5 rst pulled low while in WAIT, stray imem_rvalid afterwards -> outputs at reset values; refetch from RESET_PC.
//  6 Variable latency L=1..5, core_ready tied high -> every word delivered exactly once; instruction stable while instr_valid=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// FSM state encoding and the end-of-file instruction word.
package fetch_pkg;

  localparam int ADDR_WIDTH_DEF  = 10;
  localparam int INSTR_WIDTH_DEF = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;

  localparam logic [15:0] EOF_INSTR = 16'h0000;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: load, increment with natural wrap, or hold.
module pc_counter import fetch_pkg::*; #(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  inc_i,
  input  logic [ADDR_WIDTH-1:0] load_val_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  // Load has priority; increment wraps modulo 2^ADDR_WIDTH with no flag.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches one instruction at a time, holds it until the core takes it,
// then steps or branches the PC; stops for good on the EOF word.
module instr_fetch_unit import fetch_pkg::*; #(
  parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int                    INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_rvalid,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  input  logic                   core_ready,
  input  logic                   branch_en,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   halted,
  output logic [2:0]             dbg_state
);

  logic [2:0]             state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   accept;
  logic                   is_eof;
  logic                   pc_load;
  logic                   pc_inc;

  // Core handshake: a word transfers on a rising edge where instr_valid and
  // core_ready are both high; instruction/pc stay put until then, and
  // core_ready, branch_en and branch_target matter only on that edge.
  assign accept = (state_q == ST_HOLD) && core_ready;
  assign is_eof = (instr_q == INSTR_WIDTH'(EOF_INSTR));

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // EOF beats a coincident branch request.
        if (accept) begin
          if (is_eof) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_REQ;
            pc_load = branch_en;
            pc_inc  = !branch_en;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  pc_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_counter (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (pc_load),
    .inc_i      (pc_inc),
    .load_val_i (branch_target),
    .pc_o       (pc)
  );

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc;
  assign instruction = instr_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign halted      = (state_q == ST_HALT);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vectors, reset corner cases and a
// randomized run scored against a program-flow model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int AW  = 10;
  localparam int IW  = 16;
  localparam int SBW = AW + IW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          imem_rvalid;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic          core_ready;
  logic          branch_en;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] pc;
  logic          halted;
  logic [2:0]    dbg_state;

  logic          mem_rvalid, man_rvalid;
  logic [IW-1:0] mem_rdata, man_rdata;
  assign imem_rvalid = mem_rvalid | man_rvalid;
  assign imem_rdata  = man_rvalid ? man_rdata : mem_rdata;

  instr_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_rvalid   (imem_rvalid),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .core_ready    (core_ready),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .pc            (pc),
    .halted        (halted),
    .dbg_state     (dbg_state)
  );

  // memory model: latency fixed_lat, or random 1..5 when fixed_lat is 0
  logic [IW-1:0] mem [0:(1<<AW)-1];
  int            fixed_lat;
  bit            mem_auto;
  int            req_count;

  initial begin : mem_model
    logic [AW-1:0] a;
    int            l;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    req_count  = 0;
    forever begin
      @(negedge clk);
      if (rst && imem_req) begin
        req_count++;
        if (mem_auto) begin
          a = imem_addr;
          l = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 5);
          repeat (l) @(posedge clk);
          #1;
          mem_rvalid = 1'b1;
          mem_rdata  = mem[a];
          @(posedge clk);
          #1;
          mem_rvalid = 1'b0;
        end
      end
    end
  end

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [SBW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s valid_timeout", name), 32'(instr_valid), 32'd1);
  endtask

  typedef struct {
    logic          br;
    logic [AW-1:0] tgt;
    int            dly;
    logic [AW-1:0] exp_pc;
    logic [IW-1:0] exp_instr;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int            rc;
    int            acc;
    bit            done;
    logic [SBW-1:0] item;
    logic [AW-1:0] epc, npc;
    logic [IW-1:0] eins;

    vecs[0] = '{1'b0, 10'd0,    6, 10'd0,    16'h5306};
    vecs[1] = '{1'b1, 10'd8,    6, 10'd1,    16'h9205};
    vecs[2] = '{1'b0, 10'd0,    0, 10'd8,    16'h1234};
    vecs[3] = '{1'b1, 10'd1023, 3, 10'd9,    16'h2345};
    vecs[4] = '{1'b0, 10'd0,    1, 10'd1023, 16'habcd};
    vecs[5] = '{1'b0, 10'd0,    6, 10'd0,    16'h5306};
    vecs[6] = '{1'b0, 10'd0,    6, 10'd1,    16'h9205};
    vecs[7] = '{1'b1, 10'd5,    2, 10'd2,    16'h0000};

    rst = 1'b0; core_ready = 1'b0; branch_en = 1'b0; branch_target = '0;
    man_rvalid = 1'b0; man_rdata = '0; mem_auto = 1'b1; fixed_lat = 1;
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    mem[0] = 16'h4142;

    // reset values and first fetch with L=1
    repeat (3) @(posedge clk);
    #1;
    check("rst imem_req", 32'(imem_req), 32'd0);
    check("rst instr_valid", 32'(instr_valid), 32'd0);
    check("rst halted", 32'(halted), 32'd0);
    check("rst pc", 32'(pc), 32'd0);
    check("rst instruction", 32'(instruction), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("t1 req", 32'(imem_req), 32'd1);
    check("t1 addr", 32'(imem_addr), 32'd0);
    @(posedge clk); #1;
    check("t1 req_one_cycle", 32'(imem_req), 32'd0);
    check("t1 not_yet_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    check("t1 valid", 32'(instr_valid), 32'd1);
    check("t1 instruction", 32'(instruction), 32'h4142);

    // reset while holding a word
    rst = 1'b0;
    #1;
    check("hold_rst valid", 32'(instr_valid), 32'd0);
    check("hold_rst instruction", 32'(instruction), 32'd0);

    // directed program with branches, wrap and EOF-beats-branch
    mem[0] = 16'h5306; mem[1] = 16'h9205; mem[2] = 16'h0000;
    mem[8] = 16'h1234; mem[9] = 16'h2345; mem[1023] = 16'habcd;
    fixed_lat = 3;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_valid($sformatf("vec%0d", i));
      check($sformatf("vec%0d pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      check($sformatf("vec%0d instr", i), 32'(instruction), 32'(vecs[i].exp_instr));
      repeat (vecs[i].dly) begin
        @(posedge clk); #1;
        check($sformatf("vec%0d stable", i), 32'({instr_valid, pc, instruction}),
              32'({1'b1, vecs[i].exp_pc, vecs[i].exp_instr}));
      end
      core_ready = 1'b1; branch_en = vecs[i].br; branch_target = vecs[i].tgt;
      @(posedge clk); #1;
      core_ready = 1'b0; branch_en = 1'b1; branch_target = AW'($urandom);
      check($sformatf("vec%0d dropped", i), 32'(instr_valid), 32'd0);
    end
    rc = req_count;
    core_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    core_ready = 1'b0; branch_en = 1'b0;
    check("halt halted", 32'(halted), 32'd1);
    check("halt valid", 32'(instr_valid), 32'd0);
    check("halt pc", 32'(pc), 32'd2);
    check("halt no_req", 32'(req_count - rc), 32'd0);

    // reset mid-WAIT with stray read data
    mem_auto = 1'b0;
    mem[0] = 16'h6a01;
    @(negedge clk); rst = 1'b0;
    #1;
    check("async rst halted", 32'(halted), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("t5 req", 32'(imem_req), 32'd1);
    @(posedge clk); #1;
    man_rvalid = 1'b1; man_rdata = 16'h7777;
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    check("t5 manual word", 32'({instr_valid, instruction}), 32'({1'b1, 16'h7777}));
    core_ready = 1'b1; branch_en = 1'b1; branch_target = 10'd7;
    @(posedge clk); #1;
    core_ready = 1'b0; branch_en = 1'b0;
    check("t5 branch addr", 32'({imem_req, imem_addr}), 32'({1'b1, 10'd7}));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t5 rst pc", 32'(pc), 32'd0);
    check("t5 rst outs", 32'({imem_req, instr_valid, halted, instruction}), 32'd0);
    man_rvalid = 1'b1; man_rdata = 16'hbeef;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    check("t5 stray ignored", 32'(instr_valid), 32'd0);
    check("t5 refetch req", 32'({imem_req, imem_addr}), 32'({1'b1, 10'd0}));
    mem_auto = 1'b1; fixed_lat = 2;
    wait_valid("t5 refetch");
    check("t5 refetch word", 32'({pc, instruction}), 32'({10'd0, 16'h6a01}));
    man_rvalid = 1'b1; man_rdata = 16'hbeef;
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    check("t5 hold stray", 32'({instr_valid, instruction}), 32'({1'b1, 16'h6a01}));

    // randomized program, random latency, core_ready tied high
    rst = 1'b0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    for (int a = 0; a < 100; a++) mem[a] = IW'($urandom_range(1, 16'hffff));
    mem[1023] = IW'($urandom_range(1, 16'hffff));
    fixed_lat = 0; core_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back({AW'(0), mem[0]});
    acc = 0; done = 1'b0;
    @(negedge clk);
    rc = req_count;
    rst = 1'b1;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      branch_en = 1'($urandom_range(0, 1));
      branch_target = (acc >= 40) ? AW'(100)
                    : (($urandom_range(0, 7) == 0) ? AW'(1023) : AW'($urandom_range(0, 63)));
      if (halted) begin
        done = 1'b1;
      end else if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("rnd unexpected word", 32'({pc, instruction}), 32'hffffffff);
        end else begin
          item = exp_q.pop_front();
          epc  = item[SBW-1:IW];
          eins = item[IW-1:0];
          check($sformatf("rnd acc%0d", acc), 32'({pc, instruction}), 32'(item));
          if (eins != EOF_INSTR) begin
            npc = branch_en ? branch_target : epc + AW'(1);
            exp_q.push_back({npc, mem[npc]});
          end
        end
        acc++;
      end
    end
    check("rnd halted", 32'(done), 32'd1);
    check("rnd queue drained", 32'(exp_q.size()), 32'd0);
    check("rnd one req per word", 32'(req_count - rc), 32'(acc));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
